seq_mac_result_drain: RTL and testbench
=======================================

Name: seq_mac_result_drain

Overview:
- Consumer end of the MAC result handshake. Accepts a complete M x N matrix of 32-bit accumulator results from the bit-serial matrix MAC when a valid/ready transfer fires.
- Buffers up to two matrices, so the MAC can start its next job while the previous result is still draining.
- Streams elements out one per cycle in row-major order, each requantised with a rounding arithmetic right shift and signed saturation to OUT_WIDTH, with row/col tags and a last flag.

Parameters:
- M, 2, rows of result matrix
- N, 2, columns of result matrix
- OUT_WIDTH, 16, signed width of streamed element (2..32)
- DEPTH, 2, matrix buffer entries (fixed at 2; other values not supported)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mat_valid_i  in  1  MAC result valid (MAC valid_out)
- mat_ready_o  out  1  drain can accept a matrix (MAC ready_out)
- mat_i  in  32 x [M][N]  MAC result matrix D, signed two's complement
- shift_i  in  5  right-shift amount, sampled with the matrix
- elem_valid_o  out  1  output element valid
- elem_ready_i  in  1  downstream accepts element
- elem_data_o  out  OUT_WIDTH  requantised element, signed
- elem_row_o  out  $clog2(M) (min 1)  row index of element
- elem_col_o  out  $clog2(N) (min 1)  column index of element
- elem_sat_o  out  1  element was clipped by saturation
- elem_last_o  out  1  final element of current matrix

Behaviour:
- Single clock domain, clk_i. Asynchronous active-low reset rst_ni.
- Reset values:
  - mat_ready_o=1, elem_valid_o=0, elem_last_o=0, elem_sat_o=0, elem_data_o=0, elem_row_o=0, elem_col_o=0.
  - Buffer occupancy=0; write pointer, read pointer, row counter and column counter all 0.
- Buffer:
  - 2-entry ping-pong. Each entry holds mat_i (M*N*32 bits) plus shift_i (5 bits).
  - Occupancy counter takes values 0..2.
  - mat_ready_o = (occupancy != 2). It is driven from registers only, with no combinational path from elem_ready_i.
- Accept: mat_valid_i & mat_ready_o at a rising edge writes the entry at the write pointer, toggles the write pointer and increments occupancy.
  - mat_i is captured in full on that edge. The MAC may change D afterwards.
- Drain:
  - elem_valid_o = (occupancy != 0).
  - The element shown is entry[rd_ptr].mat[row][col], requantised with entry[rd_ptr].shift.
  - Outputs depend only on registered state; there is no combinational path from mat_valid_i.
  - First element appears the cycle after acceptance into an empty buffer (latency 1).
- Advance on elem_valid_o & elem_ready_i:
  - col increments. At col=N-1, col wraps to 0 and row increments. At row=M-1 and col=N-1, row and col wrap to 0, rd_ptr toggles and occupancy decrements.
- elem_last_o = elem_valid_o & (row==M-1) & (col==N-1).
- Simultaneous accept and final-element pop in the same cycle: occupancy is unchanged and both pointers toggle. This is legal at occupancy 1 only, because mat_ready_o is low at occupancy 2.
- Back-to-back matrices: with elem_ready_i held high, elements stream with no bubble across the matrix boundary.
- Stall: while elem_valid_o=1 and elem_ready_i=0, all elem_* outputs hold stable.
- Requantisation for each element x (signed 32-bit) with shift s:
  - s=0: y = x.
  - s>0: y = (sext33(x) + 2^(s-1)) >>> s. This is an arithmetic right shift, rounding half up.
  - Saturation: if y > 2^(OUT_WIDTH-1)-1, output the maximum and set elem_sat_o=1. If y < -2^(OUT_WIDTH-1), output the minimum and set elem_sat_o=1. Otherwise output y[OUT_WIDTH-1:0] and set elem_sat_o=0.
  - The 33-bit intermediate prevents overflow at x=0x7FFFFFFF.
- Reset mid-operation: all buffered data is discarded, the block returns to reset values, and no partial matrix is emitted.
- When elem_valid_o=0, elem_data_o, elem_row_o, elem_col_o and elem_sat_o are don't-care. elem_last_o=0.

Decomposition:
- Package seq_mac_pkg holds:
  - AccWidth=32 and ShiftWidth=5.
  - The typedef acc_mat_t for the [M][N] 32-bit matrix.
- Sub-module requant_sat (combinational): inputs x, s; outputs y and sat; parameter OUT_WIDTH. Instantiated once, on the read head.

Test Plan:
1. Single matrix, M=N=2, s=0, OUT_WIDTH=16, mat={{1,-2},{3,-4}}, elem_ready_i=1.
   - Outputs 1, -2, 3, -4 on the 4 cycles following acceptance.
   - Tags (0,0), (0,1), (1,0), (1,1).
   - elem_last_o only on -4.
   - mat_ready_o stays 1.
2. Rounding, s=2, elements {5, 6, -6, -7}.
   - Outputs 1, 2, -1, -2.
   - elem_sat_o=0 on all.
3. Saturation, s=0, elements {40000, -40000, 0x7FFFFFFF, 32767}, OUT_WIDTH=16.
   - Outputs 32767, -32768, 32767, 32767.
   - elem_sat_o = 1, 1, 1, 0.
   - s=31 on 0x7FFFFFFF gives 1 (no overflow).
4. Backpressure: elem_ready_i=0; three matrices offered.
   - Two accepted on consecutive cycles, then mat_ready_o=0 and the third waits.
   - Outputs hold the first element stable.
   - Release elem_ready_i: 8 elements stream with no bubble. mat_ready_o returns high the cycle after the first matrix's last element pops, and the third matrix is accepted.
5. Simultaneous accept and last pop at occupancy 1.
   - Occupancy stays 1.
   - The next cycle shows element (0,0) of the new matrix.
   - No element is lost or duplicated.
6. Assert rst_ni low mid-stream, during element (0,1).
   - Outputs go to reset values immediately.
   - After release, only newly accepted matrices are emitted.

Source files
------------

// File: rtl/seq_mac_pkg.sv
// rtl/seq_mac_pkg.sv - shared widths and types for the MAC result drain
package seq_mac_pkg;
   localparam int AccWidth   = 32;
   localparam int ShiftWidth = 5;
   localparam int DefRows    = 2;
   localparam int DefCols    = 2;

   // Result matrix at the default 2x2 geometry; row-major, [row][col].
   typedef logic [DefRows-1:0][DefCols-1:0][AccWidth-1:0] acc_mat_t;
endpackage

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - rounding arithmetic right shift with signed saturation
module requant_sat
   import seq_mac_pkg::*;
#(
   parameter int OUT_WIDTH = 16
) (
   input  logic [AccWidth-1:0]   x,
   input  logic [ShiftWidth-1:0] s,
   output logic [OUT_WIDTH-1:0]  y,
   output logic                  sat
);
   localparam logic signed [AccWidth:0] One    = 1;
   localparam logic signed [AccWidth:0] SatMax = (One <<< (OUT_WIDTH - 1)) - One;
   localparam logic signed [AccWidth:0] SatMin = -(One <<< (OUT_WIDTH - 1));

   logic signed [AccWidth:0] wide;
   logic signed [AccWidth:0] bias;
   logic signed [AccWidth:0] shifted;

   // One extra bit keeps x + 2^(s-1) from wrapping at the positive extreme.
   always_comb begin
      wide    = $signed({x[AccWidth-1], x});
      bias    = (s == '0) ? '0 : (One <<< (s - ShiftWidth'(1)));
      shifted = (wide + bias) >>> s;
      y       = shifted[OUT_WIDTH-1:0];
      sat     = 1'b0;
      if (shifted > SatMax) begin
         y   = SatMax[OUT_WIDTH-1:0];
         sat = 1'b1;
      end else if (shifted < SatMin) begin
         y   = SatMin[OUT_WIDTH-1:0];
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/seq_mac_result_drain.sv
// rtl/seq_mac_result_drain.sv - two-entry matrix buffer streaming requantised elements
module seq_mac_result_drain
   import seq_mac_pkg::*;
#(
   parameter int M         = 2,
   parameter int N         = 2,
   parameter int OUT_WIDTH = 16,
   parameter int DEPTH     = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 mat_valid_i,
   output logic                                 mat_ready_o,
   input  logic [M-1:0][N-1:0][AccWidth-1:0]    mat_i,
   input  logic [ShiftWidth-1:0]                shift_i,
   output logic                                 elem_valid_o,
   input  logic                                 elem_ready_i,
   output logic [OUT_WIDTH-1:0]                 elem_data_o,
   output logic [((M > 1) ? $clog2(M) : 1)-1:0] elem_row_o,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] elem_col_o,
   output logic                                 elem_sat_o,
   output logic                                 elem_last_o
);
   localparam int RowW = (M > 1) ? $clog2(M) : 1;
   localparam int ColW = (N > 1) ? $clog2(N) : 1;
   localparam int PtrW = $clog2(DEPTH);
   localparam int OccW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [M-1:0][N-1:0][AccWidth-1:0] mat;
      logic [ShiftWidth-1:0]             shift;
   } entry_t;

   entry_t              entries [DEPTH];
   logic [PtrW-1:0]     wr_ptr;
   logic [PtrW-1:0]     rd_ptr;
   logic [OccW-1:0]     occ;
   logic [RowW-1:0]     row;
   logic [ColW-1:0]     col;
   logic                push;
   logic                pop;
   logic                pop_last;
   logic                at_last;
   logic                col_end;
   entry_t              head;
   logic [OUT_WIDTH-1:0] q_data;
   logic                q_sat;

   assign mat_ready_o  = (occ != OccW'(DEPTH));
   assign elem_valid_o = (occ != '0);
   assign push         = mat_valid_i & mat_ready_o;
   assign col_end      = (col == ColW'(N - 1));
   assign at_last      = (row == RowW'(M - 1)) & col_end;
   assign pop          = elem_valid_o & elem_ready_i;
   assign pop_last     = pop & at_last;
   assign head         = entries[rd_ptr];

   // Matrix storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push) begin
         entries[wr_ptr] <= '{mat: mat_i, shift: shift_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         row    <= '0;
         col    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PtrW'(1);
         end
         if (pop) begin
            if (col_end) begin
               col <= '0;
               if (row == RowW'(M - 1)) begin
                  row    <= '0;
                  rd_ptr <= rd_ptr + PtrW'(1);
               end else begin
                  row <= row + RowW'(1);
               end
            end else begin
               col <= col + ColW'(1);
            end
         end
         case ({push, pop_last})
            2'b10:   occ <= occ + OccW'(1);
            2'b01:   occ <= occ - OccW'(1);
            default: occ <= occ;
         endcase
      end
   end

   requant_sat #(.OUT_WIDTH(OUT_WIDTH)) u_requant (
      .x   (head.mat[row][col]),
      .s   (head.shift),
      .y   (q_data),
      .sat (q_sat)
   );

   assign elem_data_o = elem_valid_o ? q_data : '0;
   assign elem_sat_o  = elem_valid_o & q_sat;
   assign elem_row_o  = elem_valid_o ? row : '0;
   assign elem_col_o  = elem_valid_o ? col : '0;
   assign elem_last_o = elem_valid_o & at_last;
endmodule

// File: tb/tb_seq_mac_result_drain.sv
// tb/tb_seq_mac_result_drain.sv - directed self-checking bench for seq_mac_result_drain
module tb_seq_mac_result_drain;
   import seq_mac_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        mat_valid;
   logic        mat_ready;
   acc_mat_t    mat;
   logic [4:0]  shift;
   logic        elem_valid;
   logic        elem_ready;
   logic [15:0] elem_data;
   logic [0:0]  elem_row;
   logic [0:0]  elem_col;
   logic        elem_sat;
   logic        elem_last;
   logic [20:0] got;
   logic [20:0] exp;

   int checks;
   int failures;

   // Requantisation vectors: shift, inputs, expected outputs, expected sat flags.
   int ts [4]    = '{2, 0, 31, 16};
   int tx [4][4] = '{'{5, 6, -6, -7},
                     '{40000, -40000, 32'h7FFFFFFF, 32767},
                     '{32'h7FFFFFFF, 32'h80000000, 32'h40000000, -1},
                     '{32'h7FFFFFFF, 32'h80000000, 32'h00018000, -98305}};
   int ty [4][4] = '{'{1, 2, -1, -2},
                     '{32767, -32768, 32767, 32767},
                     '{1, -1, 1, 0},
                     '{32767, -32768, 2, -2}};
   bit tsat [4][4] = '{'{0, 0, 0, 0}, '{1, 1, 1, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}};

   seq_mac_result_drain #(.M(2), .N(2), .OUT_WIDTH(16), .DEPTH(2)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mat_valid_i  (mat_valid),
      .mat_ready_o  (mat_ready),
      .mat_i        (mat),
      .shift_i      (shift),
      .elem_valid_o (elem_valid),
      .elem_ready_i (elem_ready),
      .elem_data_o  (elem_data),
      .elem_row_o   (elem_row),
      .elem_col_o   (elem_col),
      .elem_sat_o   (elem_sat),
      .elem_last_o  (elem_last)
   );

   assign got = {elem_valid, elem_last, elem_sat, elem_row, elem_col, elem_data};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   function automatic logic [20:0] pk(input logic l, input logic s, input int r, input int c,
                                      input int d);
      logic [15:0] dd;
      dd = d[15:0];
      return {1'b1, l, s, r[0], c[0], dd};
   endfunction

   task automatic set_mat(input int a, input int b, input int c, input int d);
      mat[0][0] = a;
      mat[0][1] = b;
      mat[1][0] = c;
      mat[1][1] = d;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (got !== 21'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", got, 21'h0);
      end
      checks++;
      if (mat_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", mat_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (elem_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_valid got=%b exp=0", elem_valid);
      end
   endtask

   task automatic test_single();
      set_mat(1, -2, 3, -4);
      shift = 5'd0;
      elem_ready = 1'b1;
      mat_valid = 1'b1;
      @(negedge clk);
      mat_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp = pk(k == 3, 1'b0, k / 2, k % 2, (k % 2 == 0) ? (k + 1) : -(k + 1));
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL single k=%0d got=%h exp=%h", k, got, exp);
         end
         checks++;
         if (mat_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready k=%0d got=%b exp=1", k, mat_ready);
         end
         @(negedge clk);
      end
      checks++;
      if (elem_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_end_valid got=%b exp=0", elem_valid);
      end
   endtask

   task automatic test_requant();
      elem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_mat(tx[i][0], tx[i][1], tx[i][2], tx[i][3]);
         shift = 5'(ts[i]);
         mat_valid = 1'b1;
         @(negedge clk);
         mat_valid = 1'b0;
         for (int k = 0; k < 4; k++) begin
            exp = pk(k == 3, tsat[i][k], k / 2, k % 2, ty[i][k]);
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL requant m=%0d k=%0d got=%h exp=%h", i, k, got, exp);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_backpressure();
      elem_ready = 1'b0;
      shift = 5'd0;
      set_mat(10, 11, 12, 13);
      mat_valid = 1'b1;
      @(negedge clk);
      set_mat(20, 21, 22, 23);
      checks++;
      if (mat_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_ready_occ1 got=%b exp=1", mat_ready);
      end
      @(negedge clk);
      set_mat(30, 31, 32, 33);
      for (int j = 0; j < 3; j++) begin
         exp = pk(1'b0, 1'b0, 0, 0, 10);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL bp_stall j=%0d got=%h exp=%h", j, got, exp);
         end
         checks++;
         if (mat_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_full j=%0d got=%b exp=0", j, mat_ready);
         end
         @(negedge clk);
      end
      elem_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         exp = pk(k % 4 == 3, 1'b0, (k % 4) / 2, k % 2, (k / 4 + 1) * 10 + k % 4);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL bp_stream k=%0d got=%h exp=%h", k, got, exp);
         end
         checks++;
         if (mat_ready !== (k == 4 || k >= 8)) begin
            failures++;
            $display("FAIL bp_stream_ready k=%0d got=%b exp=%b", k, mat_ready, (k == 4 || k >= 8));
         end
         @(negedge clk);
         if (k == 4) mat_valid = 1'b0;
      end
      checks++;
      if (elem_valid !== 1'b0 || mat_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_end got=%b%b exp=01", elem_valid, mat_ready);
      end
   endtask

   task automatic test_simul();
      elem_ready = 1'b1;
      shift = 5'd0;
      set_mat(1, 2, 3, 4);
      mat_valid = 1'b1;
      @(negedge clk);
      mat_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         exp = pk(k % 4 == 3, 1'b0, (k % 4) / 2, k % 2, k + 1);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL simul k=%0d got=%h exp=%h", k, got, exp);
         end
         checks++;
         if (mat_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_ready k=%0d got=%b exp=1", k, mat_ready);
         end
         if (k == 3) begin
            set_mat(5, 6, 7, 8);
            mat_valid = 1'b1;
         end
         @(negedge clk);
         mat_valid = 1'b0;
      end
      checks++;
      if (elem_valid !== 1'b0) begin
         failures++;
         $display("FAIL simul_end_valid got=%b exp=0", elem_valid);
      end
   endtask

   task automatic test_reset_mid();
      elem_ready = 1'b1;
      shift = 5'd0;
      set_mat(100, 101, 102, 103);
      mat_valid = 1'b1;
      @(negedge clk);
      mat_valid = 1'b0;
      @(negedge clk);
      exp = pk(1'b0, 1'b0, 0, 1, 101);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL rstmid_pre got=%h exp=%h", got, exp);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (got !== 21'h0 || mat_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_async got=%h/%b exp=%h/1", got, mat_ready, 21'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (elem_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_no_partial got=%b exp=0", elem_valid);
      end
      set_mat(200, -201, 202, -203);
      mat_valid = 1'b1;
      @(negedge clk);
      mat_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp = pk(k == 3, 1'b0, k / 2, k % 2, (k % 2 == 0) ? (200 + k) : -(200 + k));
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rstmid_new k=%0d got=%h exp=%h", k, got, exp);
         end
         @(negedge clk);
      end
      checks++;
      if (elem_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_end_valid got=%b exp=0", elem_valid);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      mat_valid  = 1'b0;
      elem_ready = 1'b0;
      shift      = 5'd0;
      mat        = '0;
      test_reset();
      test_single();
      test_requant();
      test_backpressure();
      test_simul();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
